// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one instruction-memory
// request at a time, and fills the IF/ID register. A one-entry hold buffer
// catches a response that lands while decode is stalling a live instruction,
// and an execute-stage redirect flushes IF/ID and kills any in-flight fetch.
module fetch_sequencer #(
   parameter int unsigned          XLEN     = 32,
   parameter logic [XLEN-1:0]      RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_d,
   input  logic            redirect_e,
   input  logic [XLEN-1:0] redirect_pc_e,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr_d,
   output logic [XLEN-1:0] pc_d,
   output logic [XLEN-1:0] pc_plus4_d,
   output logic            valid_d
);

   localparam logic [XLEN-1:0] InstrBytes = XLEN'(4);

   typedef enum logic [1:0] {SReq, SWait, SHold} fetchState_e;

   fetchState_e     state;
   logic [XLEN-1:0] pcF;
   logic [XLEN-1:0] pendPc;
   logic            kill;
   logic [XLEN-1:0] holdInstr;
   logic [XLEN-1:0] holdPc;

   // Request is gated by reset so it reads 0 while reset is held.
   assign imem_req  = rst & (state == SReq);
   assign imem_addr = pcF;

   // Sequencer state, fetch PC, outstanding-request tag, hold buffer and IF/ID.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= SReq;
         pcF        <= RESET_PC;
         pendPc     <= '0;
         kill       <= 1'b0;
         holdInstr  <= '0;
         holdPc     <= '0;
         instr_d    <= '0;
         pc_d       <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (redirect_e) begin
         // Flush wins over stall; anything fetched on the old path is dropped.
         pcF     <= redirect_pc_e;
         valid_d <= 1'b0;
         unique case (state)
            SReq: begin
               if (imem_gnt) begin
                  // Request to the old path already accepted: let it return, then drop it.
                  pendPc <= pcF;
                  kill   <= 1'b1;
                  state  <= SWait;
               end
            end
            SWait: begin
               if (imem_rvalid) begin
                  kill  <= 1'b0;
                  state <= SReq;
               end else begin
                  kill <= 1'b1;
               end
            end
            SHold: state <= SReq;
            default: state <= SReq;
         endcase
      end else begin
         // Bubble unless decode is holding the slot; overridden below on new data.
         if (!stall_d) begin
            valid_d <= 1'b0;
         end
         unique case (state)
            SReq: begin
               if (imem_gnt) begin
                  pendPc <= pcF;
                  pcF    <= pcF + InstrBytes;
                  state  <= SWait;
               end
            end
            SWait: begin
               if (imem_rvalid) begin
                  if (kill) begin
                     kill  <= 1'b0;
                     state <= SReq;
                  end else if (valid_d && stall_d) begin
                     holdInstr <= imem_rdata;
                     holdPc    <= pendPc;
                     state     <= SHold;
                  end else begin
                     instr_d    <= imem_rdata;
                     pc_d       <= pendPc;
                     pc_plus4_d <= pendPc + InstrBytes;
                     valid_d    <= 1'b1;
                     state      <= SReq;
                  end
               end
            end
            SHold: begin
               if (!stall_d) begin
                  instr_d    <= holdInstr;
                  pc_d       <= holdPc;
                  pc_plus4_d <= holdPc + InstrBytes;
                  valid_d    <= 1'b1;
                  state      <= SReq;
               end
            end
            default: state <= SReq;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a variable-latency memory model, a program-order
// scoreboard of expected instructions, a monitor that checks every instruction
// leaving IF/ID, plus directed scenarios for stall, redirect and reset.
module tb_fetch_sequencer;
   localparam int unsigned XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] MemKey   = 32'hA5A5_0000;

   logic        clk, rst, stall_d, redirect_e;
   logic [31:0] redirect_pc_e;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] instr_d, pc_d, pc_plus4_d;
   logic        valid_d;

   fetch_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_d      (stall_d),
      .redirect_e   (redirect_e),
      .redirect_pc_e(redirect_pc_e),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instr_d      (instr_d),
      .pc_d         (pc_d),
      .pc_plus4_d   (pc_plus4_d),
      .valid_d      (valid_d)
   );

   int          passCnt = 0;
   int          totalCnt = 0;
   int          memLat = 0;
   int          gntPct = 100;
   bit          outstanding;
   int          grantCount = 0;
   int          grantTaken;
   int          waitCnt;
   int          logBase = 0;
   logic [31:0] grantAddr, respAddr;
   logic [31:0] grantLog[$];
   logic [31:0] expQ[$];
   logic [31:0] expNext;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Memory: accepts a grant, answers after memLat cycles (random 0..3 when negative).
   initial begin
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      outstanding = 1'b0; grantTaken = 0; waitCnt = 0; respAddr = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            outstanding = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0; grantTaken = grantCount;
         end else begin
            if (imem_rvalid) begin
               outstanding = 1'b0; imem_rvalid = 1'b0;
            end
            if (grantCount != grantTaken) begin
               grantTaken = grantCount; outstanding = 1'b1; respAddr = grantAddr;
               waitCnt = (memLat < 0) ? int'($urandom_range(0, 3)) : memLat;
            end
            if (outstanding && waitCnt == 0) begin
               imem_rvalid = 1'b1; imem_rdata = respAddr ^ MemKey;
            end else if (outstanding) begin
               waitCnt--;
            end
            imem_gnt = ($urandom_range(0, 99) < gntPct);
         end
      end
   end

   // Monitor: protocol, flush, redirect-target and scoreboard checks mid-cycle.
   initial begin : monitor
      bit          redirPend, prevRedir;
      logic [31:0] redirTarget, e;
      redirPend = 1'b1; redirTarget = RESET_PC; prevRedir = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            redirPend = 1'b1; redirTarget = RESET_PC; prevRedir = 1'b0;
         end else begin
            if (prevRedir) chk("flush_valid", {31'b0, valid_d}, 32'd0);
            if (imem_req) chk("one_outstanding", {31'b0, outstanding}, 32'd0);
            if (imem_req && imem_gnt) begin
               if (!redirect_e && redirPend) begin
                  chk("fetch_target", imem_addr, redirTarget);
                  redirPend = 1'b0;
               end
               grantAddr = imem_addr;
               grantLog.push_back(imem_addr);
               grantCount++;
            end
            if (redirect_e) begin
               redirPend = 1'b1; redirTarget = redirect_pc_e;
            end
            if (valid_d && !stall_d && !redirect_e) begin
               if (expQ.size() == 0) begin
                  chk("sb_underflow_pc", pc_d, 32'hFFFF_FFFF);
               end else begin
                  e = expQ.pop_front();
                  chk("sb_pc", pc_d, e);
                  chk("sb_instr", instr_d, e ^ MemKey);
                  chk("sb_pc_plus4", pc_plus4_d, e + 32'd4);
               end
            end
            prevRedir = redirect_e;
         end
      end
   end

   // Program-order stream: sequential from the last restart point.
   task automatic topUp();
      while (expQ.size() < 8) begin
         expQ.push_back(expNext);
         expNext = expNext + 32'd4;
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
      topUp();
   endtask

   task automatic redirect(input logic [31:0] tgt);
      redirect_e = 1'b1; redirect_pc_e = tgt;
      expQ.delete(); expNext = tgt; topUp();
   endtask

   task automatic holdReset();
      stall_d = 1'b0; redirect_e = 1'b0; redirect_pc_e = '0;
      expQ.delete(); expNext = RESET_PC; topUp();
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_instr", instr_d, 32'd0);
      chk("rst_pc", pc_d, 32'd0);
      chk("rst_pc_plus4", pc_plus4_d, 32'd0);
      chk("rst_valid", {31'b0, valid_d}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      logBase = grantLog.size();
      rst = 1'b1;
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      rst = 1'b0;
      holdReset();
   endtask

   task automatic waitValid(input string name);
      for (int i = 0; i < 60; i++) begin
         tick();
         if (valid_d) return;
      end
      chk(name, {31'b0, valid_d}, 32'd1);
   endtask

   task automatic waitPc(input string name, input logic [31:0] pc);
      for (int i = 0; i < 60; i++) begin
         tick();
         if (valid_d && pc_d == pc) return;
      end
      chk(name, pc_d, pc);
   endtask

   task automatic waitGrants(input string name, input int n);
      for (int i = 0; i < 80; i++) begin
         tick();
         if (grantLog.size() - logBase >= n) return;
      end
      chk(name, grantLog.size() - logBase, n);
   endtask

   initial begin
      logic [31:0] tgt;
      bit          found;
      rst = 1'b0; stall_d = 1'b0; redirect_e = 1'b0; redirect_pc_e = '0;
      expNext = RESET_PC;

      // Zero-wait memory: one instruction every two cycles.
      memLat = 0; gntPct = 100; doReset();
      waitValid("a_first_valid");
      chk("a_pc0", pc_d, 32'h0);
      chk("a_instr0", instr_d, 32'hA5A5_0000);
      tick(); chk("a_toggle0", {31'b0, valid_d}, 32'd0);
      tick(); chk("a_toggle1", {31'b0, valid_d}, 32'd1);
      chk("a_pc4", pc_d, 32'h4);
      chk("a_instr4", instr_d, 32'hA5A5_0004);
      tick(); chk("a_toggle2", {31'b0, valid_d}, 32'd0);
      tick(); chk("a_toggle3", {31'b0, valid_d}, 32'd1);
      for (int i = 0; i < 3; i++)
         chk("a_addr_seq", (grantLog.size() > logBase + i) ? grantLog[logBase + i] : 32'hDEAD_BEEF,
             32'(i * 4));

      // Stall while the response for PC 8 arrives: hold buffer, no request.
      doReset();
      waitPc("b_reach_pc4", 32'h4);
      stall_d = 1'b1;
      tick(); tick();
      chk("b_hold_no_req", {31'b0, imem_req}, 32'd0);
      chk("b_hold_pc", pc_d, 32'h4);
      chk("b_hold_valid", {31'b0, valid_d}, 32'd1);
      tick();
      chk("b_hold_no_req2", {31'b0, imem_req}, 32'd0);
      stall_d = 1'b0;
      tick();
      chk("b_release_pc", pc_d, 32'h8);
      chk("b_release_valid", {31'b0, valid_d}, 32'd1);

      // Redirect while the fetch of 0xC is outstanding.
      memLat = 2; doReset();
      waitGrants("c_grants", 4);
      chk("c_wait_addr", (grantLog.size() > logBase + 3) ? grantLog[logBase + 3] : 32'hDEAD_BEEF,
          32'hC);
      redirect(32'h100);
      tick(); redirect_e = 1'b0;
      chk("c_flush", {31'b0, valid_d}, 32'd0);
      waitValid("c_target_valid");
      chk("c_target_pc", pc_d, 32'h100);

      // Redirect while stalled with a full hold buffer.
      memLat = 0; doReset();
      waitPc("d_reach_pc4", 32'h4);
      stall_d = 1'b1;
      tick(); tick();
      redirect(32'h40);
      tick(); redirect_e = 1'b0; stall_d = 1'b0;
      chk("d_flush", {31'b0, valid_d}, 32'd0);
      waitValid("d_target_valid");
      chk("d_target_pc", pc_d, 32'h40);

      // Grant and redirect in the same cycle.
      doReset();
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         found = imem_req && imem_addr == 32'h20;
      end
      if (!found) chk("e_reach_20", imem_addr, 32'h20);
      redirect(32'h80);
      tick(); redirect_e = 1'b0;
      waitValid("e_target_valid");
      chk("e_target_pc", pc_d, 32'h80);

      // Asynchronous reset in the middle of a 5-cycle wait.
      memLat = 5; doReset();
      waitGrants("f_grants", 3);
      #3 rst = 1'b0;
      holdReset();
      tick(); chk("f_no_stale0", {31'b0, valid_d}, 32'd0);
      tick(); chk("f_no_stale1", {31'b0, valid_d}, 32'd0);
      waitValid("f_valid");
      chk("f_first_pc", pc_d, RESET_PC);
      chk("f_first_addr", (grantLog.size() > logBase) ? grantLog[logBase] : 32'hDEAD_BEEF,
          RESET_PC);

      // Randomized stall, grant, latency and redirect traffic, including wrap.
      memLat = -1; gntPct = 60; doReset();
      for (int i = 0; i < 1500; i++) begin
         tick();
         stall_d = ($urandom_range(0, 99) < 30);
         if (redirect_e) begin
            redirect_e = 1'b0;
         end else if ($urandom_range(0, 99) < 8) begin
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF4;
            else tgt = 32'($urandom_range(0, 1023)) << 2;
            redirect(tgt);
         end
      end
      stall_d = 1'b0; redirect_e = 1'b0;
      repeat (40) tick();

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
